// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage issuing word loads/stores over a req/ack bus, stalling upstream until done
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALU_data_i,
  input  logic [31:0] Store_data_i,
  input  logic [4:0]  RegWriteAddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        err_o,
  output logic [1:0]  WB_o,
  output logic [31:0] MEM_data_o,
  output logic [31:0] ALU_data_o,
  output logic [4:0]  RegWriteAddr_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic abort, op, mis, issue, tmo;
  assign op             = MemRead_i | MemWrite_i;
  assign mis            = op & (ALU_data_i[1:0] != 2'b00);
  assign issue          = (state == IDLE) & op & ~mis;
  assign tmo            = (state == BUSY) & ~mem_ack_i & (cnt == CNT_W'(TIMEOUT - 1));
  assign ALU_data_o     = ALU_data_i;
  assign RegWriteAddr_o = RegWriteAddr_i;
  always_comb begin
    state_nx = issue ? BUSY :
               (state == BUSY && (mem_ack_i || tmo)) ? DONE :
               (state == DONE) ? IDLE : state;
    stall_o  = issue | (state == BUSY);
    WB_o     = (state == IDLE) ? (op ? 2'b00 : WB_i) :
               (state == DONE && !abort) ? WB_i : 2'b00;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      abort       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      MEM_data_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      state <= state_nx;
      err_o <= ((state == IDLE) & mis) | tmo;
      if (issue) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= MemWrite_i;
        mem_addr_o  <= ALU_data_i;
        mem_wdata_o <= Store_data_i;
        cnt         <= '0;
      end
      if (state == BUSY) begin
        if (mem_ack_i) begin
          mem_req_o <= 1'b0;
          if (!mem_we_o) MEM_data_o <= mem_rdata_i;
        end else if (tmo) begin
          mem_req_o <= 1'b0;
          abort     <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (state == DONE) abort <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: per-instruction transaction model of the MEM stage driven with directed and random ops
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        MemRead_i = 1'b0, MemWrite_i = 1'b0, mem_ack_i = 1'b0;
  logic [1:0]  WB_i = '0;
  logic [31:0] ALU_data_i = '0, Store_data_i = '0, mem_rdata_i = '0;
  logic [4:0]  RegWriteAddr_i = '0;
  logic        mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, MEM_data_o, ALU_data_o;
  logic [1:0]  WB_o;
  logic [4:0]  RegWriteAddr_o;
  int total = 0, bad = 0;
  logic [31:0] mdata = '0;
  logic        exp_err = 1'b0;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .WB_i(WB_i), .ALU_data_i(ALU_data_i), .Store_data_i(Store_data_i),
    .RegWriteAddr_i(RegWriteAddr_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .stall_o(stall_o), .err_o(err_o), .WB_o(WB_o),
    .MEM_data_o(MEM_data_o), .ALU_data_o(ALU_data_o), .RegWriteAddr_o(RegWriteAddr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // kind: 0 none, 1 load, 2 store, 3 read+write (acts as store); d: ack in BUSY cycle d, 0 = never
  task automatic instr(input int kind, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [1:0] wb, input int d);
    bit op, mis, acked, we;
    op    = (kind != 0);
    mis   = op && (a[1:0] != 2'b00);
    we    = (kind >= 2);
    acked = (d >= 1) && (d <= TIMEOUT);
    tick();
    MemRead_i      = (kind == 1) || (kind == 3);
    MemWrite_i     = we;
    ALU_data_i     = a;
    Store_data_i   = wd;
    WB_i           = wb;
    RegWriteAddr_i = 5'($urandom);
    mem_ack_i      = 1'($urandom);
    mem_rdata_i    = $urandom;
    #1;
    chk("err_prev", err_o, exp_err);
    chk("req_idle", mem_req_o, 0);
    chk("mdata_idle", MEM_data_o, mdata);
    chk("alu_pass", ALU_data_o, a);
    chk("rd_pass", RegWriteAddr_o, RegWriteAddr_i);
    chk("stall_first", stall_o, op && !mis);
    chk("wb_first", WB_o, op ? 2'b00 : wb);
    exp_err = mis;
    if (!op || mis) return;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      mem_ack_i   = (k == d);
      mem_rdata_i = (k == d) ? rd : $urandom;
      #1;
      chk("stall_busy", stall_o, 1);
      chk("wb_busy", WB_o, 0);
      chk("req_busy", mem_req_o, 1);
      chk("we_busy", mem_we_o, we);
      chk("addr_busy", mem_addr_o, a);
      chk("wdata_busy", mem_wdata_o, wd);
      chk("err_busy", err_o, 0);
      chk("mdata_busy", MEM_data_o, mdata);
      if (k == d) break;
    end
    if (acked && !we) mdata = rd;
    tick();
    mem_ack_i   = 1'($urandom);
    mem_rdata_i = $urandom;
    #1;
    chk("stall_done", stall_o, 0);
    chk("wb_done", WB_o, acked ? wb : 2'b00);
    chk("req_done", mem_req_o, 0);
    chk("err_done", err_o, !acked);
    chk("mdata_done", MEM_data_o, mdata);
    exp_err = 1'b0;
  endtask

  initial begin
    WB_i = 2'b10;
    tick();
    tick();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_mdata", MEM_data_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_wb", WB_o, 2'b10);
    rst_i = 1'b1;
    instr(1, 32'h100, 32'h0, 32'hDEADBEEF, 2'b11, 1);
    instr(2, 32'h204, 32'h12345678, 32'hAAAA5555, 2'b01, 3);
    instr(1, 32'h103, 32'h0, 32'h0, 2'b11, 1);
    instr(0, 32'h40, 32'h0, 32'h0, 2'b10, 0);
    instr(1, 32'h108, 32'h0, 32'h0, 2'b11, 0);
    instr(0, 32'h44, 32'h0, 32'h0, 2'b10, 0);
    instr(1, 32'h10C, 32'h0, 32'hCAFEF00D, 2'b11, TIMEOUT);
    instr(1, 32'h110, 32'h0, 32'h11112222, 2'b11, 1);
    instr(1, 32'h114, 32'h0, 32'h33334444, 2'b11, 2);
    instr(0, 32'h55, 32'h0, 32'h0, 2'b10, 0);
    instr(3, 32'h118, 32'h9, 32'h77778888, 2'b01, 2);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int d;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      d = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 0 : TIMEOUT) : int'($urandom_range(6, 1));
      instr(int'($urandom_range(3)), a, $urandom, $urandom, 2'($urandom), d);
    end
    instr(1, 32'h300, 32'h0, 32'h0, 2'b11, 1);
    tick();
    MemRead_i = 1'b1;
    ALU_data_i = 32'h400;
    WB_i = 2'b11;
    mem_ack_i = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("pre_rst_req", mem_req_o, 1);
    tick();
    rst_i = 1'b0;
    MemRead_i = 1'b0;
    WB_i = 2'b01;
    tick();
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_we", mem_we_o, 0);
    chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_wdata", mem_wdata_o, 0);
    chk("mid_rst_mdata", MEM_data_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_wb", WB_o, 2'b01);
    rst_i = 1'b1;
    mdata = '0;
    exp_err = 1'b0;
    instr(0, 32'h0, 32'h0, 32'h0, 2'b10, 0);
    instr(1, 32'h500, 32'h0, 32'h0BADF00D, 2'b11, 2);
    instr(0, 32'h0, 32'h0, 32'h0, 2'b10, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
